rs_encoder_15_11: RTL and testbench
===================================

# rs_encoder_15_11

Systematic RS(15,11) encoder over GF(16) (primitive polynomial x^4+x+1). It accepts 11 message symbols through a valid/ready handshake and emits a 15-symbol serial codeword: the 11 message symbols followed by 4 parity symbols. It sits directly upstream of the RS(15,11) decoder, and its codeword stream feeds the decoder's serial symbol input.

## Interface
Parameters:
- None. Code geometry (n=15, k=11, 4-bit symbols) and the generator are fixed.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset; asserted while 0.
- in_symbol  in  4  message symbol.
- in_valid  in  1  in_symbol is valid this cycle.
- in_ready  out  1  encoder accepts a symbol this cycle; combinational from state (high iff state DATA).
- out_symbol  out  4  codeword symbol, registered.
- out_valid  out  1  out_symbol is a codeword symbol this cycle.
- out_sof  out  1  high with the first symbol of a codeword (message symbol 0).
- out_eof  out  1  high with the last symbol of a codeword (parity p0).

## Operation
- Generator: g(x) = (x+α^0)(x+α^1)(x+α^2)(x+α^3) = x^4 + 15x^3 + 3x^2 + 1x + 12. Coefficients are decimal symbol values; α=2.
- Symbols are transmitted highest degree first. The message occupies c14..c4. The parity p3..p0 = c3..c0 is the remainder of m(x)·x^4 mod g(x).
- Encoder state: parity registers p3..p0 (4 bits each), a symbol counter cnt (0..14), and an FSM state.
- State DATA (in_ready=1): on in_valid, the symbol is accepted.
  - Compute fb = in_symbol ^ p3.
  - Update p3←p2^(15·fb), p2←p1^(3·fb), p1←p0^(1·fb), p0←12·fb. All products are GF(16) constant multiplies and all additions are XOR.
  - Register out_symbol←in_symbol, out_valid←1, out_sof←(cnt==0), then cnt←cnt+1.
  - On acceptance with cnt==10, move to PARITY.
- Bubbles: a cycle in DATA with in_valid=0 produces out_valid=0 and leaves all state unchanged. Codeword continuity is the source's responsibility.
- State PARITY (in_ready=0), one symbol per cycle for 4 cycles:
  - out_symbol←p3, out_valid←1, then shift p3←p2, p2←p1, p1←p0, p0←0.
  - out_eof←1 on the cycle with cnt==14.
  - After cnt==14: cnt←0, parity registers are zero, and the FSM returns to DATA.
- in_valid during PARITY is ignored; no symbol is accepted.
- Reset (RESET=0), at any time including mid-codeword:
  - state DATA, cnt 0, p3..p0 0.
  - out_symbol 0, out_valid 0, out_sof 0, out_eof 0.
  - The partial codeword is discarded and no residual parity is emitted.

## Timing
- Latency: a symbol accepted at edge t appears on out_symbol after edge t (1 cycle, registered).
- The 11th message symbol is accepted at edge k. Parity p3, p2, p1, p0 are presented after edges k+1 .. k+4. A new message symbol can be accepted from edge k+5.
- With in_valid held high, output is gap-free at 15 symbols per codeword, and in_ready shows a duty of 11 of every 15 cycles.
- out_sof and out_eof are one-cycle pulses, each coincident with out_valid=1.

## Configuration
- RS_ENC_ERR_INJECT_EN defined:
  - Adds input port inj_err [3:0].
  - out_symbol is the codeword symbol XOR the inj_err value sampled at the same edge.
  - Injection does not affect the parity computation, so injected symbols are channel errors for decoder verification.
- Not defined: the port is absent and out_symbol is the pure codeword.

## Test plan
- Reset: hold RESET=0 with stimulus toggling. Required: all outputs stay 0 and in_ready=1. After release, the first accepted symbol has out_sof=1.
- All-zero message, 11 zeros with in_valid held high. Required: 15 output symbols, all 0. out_sof on the 1st symbol, out_eof on the 15th, in_ready low for exactly 4 cycles.
- Message 0,…,0,1 (only the last symbol is 1). Required: parity output is 15, 3, 1, 12, so the codeword equals g(x).
- Random messages with random in_valid bubbles, against a reference model. Required:
  - The codeword matches the model.
  - All four syndromes computed at α^0..α^3 are 0.
  - out_valid is low exactly on the bubble cycles.
- Mid-operation reset: apply RESET=0 after 6 accepted symbols. Required: no parity is emitted. The next 11 symbols form a correct, fresh codeword.
- With RS_ENC_ERR_INJECT_EN: inj_err=4'h5 on codeword position 3 only. Required: output differs from the clean codeword only at that position, by XOR 5. The parity is unchanged.

Source files
------------

// File: rtl/rs_encoder_15_11.sv
// rtl/rs_encoder_15_11.sv - Systematic RS(15,11) encoder over GF(16), serial codeword output
//
// Purpose:
//   Accepts 11 four-bit message symbols through a valid/ready handshake and
//   emits a 15-symbol codeword: the 11 message symbols, then parity p3..p0.
//   Field: GF(16), primitive polynomial x^4+x+1, alpha = 2.
//   Generator: g(x) = x^4 + 15x^3 + 3x^2 + 1x + 12.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-low reset
//   in_symbol   in   [3:0] message symbol
//   in_valid    in   in_symbol valid this cycle
//   inj_err     in   [3:0] error pattern XORed onto out_symbol
//                    (present only when RS_ENC_ERR_INJECT_EN is defined)
//   in_ready    out  high while the encoder accepts message symbols
//   out_symbol  out  [3:0] registered codeword symbol
//   out_valid   out  out_symbol carries a codeword symbol
//   out_sof     out  first symbol of a codeword
//   out_eof     out  last symbol of a codeword (parity p0)
//
// Build option:
//   RS_ENC_ERR_INJECT_EN - adds inj_err; injected errors never reach the
//   parity registers, so they look like channel errors downstream.

module rs_encoder_15_11 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] in_symbol,
    input  logic       in_valid,
`ifdef RS_ENC_ERR_INJECT_EN
    input  logic [3:0] inj_err,
`endif
    output logic       in_ready,
    output logic [3:0] out_symbol,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eof
);

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    localparam logic [3:0] G3 = 4'd15;
    localparam logic [3:0] G2 = 4'd3;
    localparam logic [3:0] G1 = 4'd1;
    localparam logic [3:0] G0 = 4'd12;

    localparam logic [3:0] CNT_LAST_MSG = 4'd10;
    localparam logic [3:0] CNT_LAST_SYM = 4'd14;

    // Shift-and-add multiply; with constant b this collapses to an XOR network.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'd0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            // multiply by alpha: x^4 reduces to x + 1
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'b0011 : 4'b0000);
        end
        return acc;
    endfunction

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] p3_q;
    logic [3:0] p2_q;
    logic [3:0] p1_q;
    logic [3:0] p0_q;
    logic [3:0] out_symbol_q;
    logic       out_valid_q;
    logic       out_sof_q;
    logic       out_eof_q;

    logic [3:0] err_mask;
    logic [3:0] fb;

`ifdef RS_ENC_ERR_INJECT_EN
    assign err_mask = inj_err;
`else
    assign err_mask = 4'd0;
`endif

    // Feedback term of the division LFSR.
    assign fb = in_symbol ^ p3_q;

    assign in_ready   = (state_q == ST_DATA);
    assign out_symbol = out_symbol_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_DATA;
            cnt_q        <= 4'd0;
            p3_q         <= 4'd0;
            p2_q         <= 4'd0;
            p1_q         <= 4'd0;
            p0_q         <= 4'd0;
            out_symbol_q <= 4'd0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (in_valid) begin
                        p3_q         <= p2_q ^ gf_mul(fb, G3);
                        p2_q         <= p1_q ^ gf_mul(fb, G2);
                        p1_q         <= p0_q ^ gf_mul(fb, G1);
                        p0_q         <= gf_mul(fb, G0);
                        out_symbol_q <= in_symbol ^ err_mask;
                        out_valid_q  <= 1'b1;
                        out_sof_q    <= (cnt_q == 4'd0);
                        out_eof_q    <= 1'b0;
                        cnt_q        <= cnt_q + 4'd1;
                        if (cnt_q == CNT_LAST_MSG) begin
                            state_q <= ST_PARITY;
                        end
                    end else begin
                        // Bubble: hold encoder state, output nothing.
                        out_valid_q <= 1'b0;
                        out_sof_q   <= 1'b0;
                        out_eof_q   <= 1'b0;
                    end
                end

                ST_PARITY: begin
                    // Drain parity highest degree first; zero fill leaves
                    // the registers clear for the next codeword.
                    out_symbol_q <= p3_q ^ err_mask;
                    out_valid_q  <= 1'b1;
                    out_sof_q    <= 1'b0;
                    out_eof_q    <= (cnt_q == CNT_LAST_SYM);
                    p3_q         <= p2_q;
                    p2_q         <= p1_q;
                    p1_q         <= p0_q;
                    p0_q         <= 4'd0;
                    if (cnt_q == CNT_LAST_SYM) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_q <= ST_DATA;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_15_11.sv
// tb/tb_rs_encoder_15_11.sv - Self-checking bench for rs_encoder_15_11 against a polynomial-division model

module tb_rs_encoder_15_11;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] in_symbol = 4'd0;
    logic       in_valid = 1'b0;
    logic [3:0] inj_err = 4'd0;
    logic       in_ready;
    logic [3:0] out_symbol;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;

    always #5 CLK = ~CLK;

    rs_encoder_15_11 dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_symbol  (in_symbol),
        .in_valid   (in_valid),
`ifdef RS_ENC_ERR_INJECT_EN
        .inj_err    (inj_err),
`endif
        .in_ready   (in_ready),
        .out_symbol (out_symbol),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eof    (out_eof)
    );

    int checks = 0;
    int failures = 0;
    bit started = 0;

    int gexp [0:14];
    int glog [0:15];
    logic [3:0] gpoly [0:4] = '{4'd12, 4'd1, 4'd3, 4'd15, 4'd1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] tb_mul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0 || b == 4'd0) return 4'd0;
        return 4'(gexp[(glog[a] + glog[b]) % 15]);
    endfunction

    // Remainder of m(x)*x^4 divided by g(x), by schoolbook long division.
    // m[43:40] is message symbol 0 (degree 14). Result is {p3,p2,p1,p0}.
    function automatic logic [15:0] calc_parity(input logic [43:0] m);
        logic [3:0] c [0:14];
        logic [3:0] coef;
        for (int i = 0; i < 11; i++) c[14-i] = m[43-4*i -: 4];
        for (int i = 0; i < 4; i++) c[i] = 4'd0;
        for (int d = 14; d >= 4; d--) begin
            coef = c[d];
            for (int j = 0; j <= 4; j++) c[d-4+j] = c[d-4+j] ^ tb_mul(coef, gpoly[j]);
        end
        return {c[3], c[2], c[1], c[0]};
    endfunction

    // Codeword evaluated at alpha^j; cw[59:56] is degree 14.
    function automatic logic [3:0] syndrome(input logic [59:0] cw, input int j);
        logic [3:0] s;
        logic [3:0] aj;
        s  = 4'd0;
        aj = 4'(gexp[j]);
        for (int i = 0; i < 15; i++) s = tb_mul(s, aj) ^ cw[59-4*i -: 4];
        return s;
    endfunction

    // ---------------- reference model ----------------
    logic [43:0] m_msg = '0;
    int          m_cnt = 0;
    logic [3:0]  par_q [$];
    logic        exp_valid = 1'b0;
    logic        exp_sof = 1'b0;
    logic        exp_eof = 1'b0;
    logic        exp_ready = 1'b1;
    logic [3:0]  exp_sym = 4'd0;
    logic [59:0] clean_cw = '0;
    logic        m_inj = 1'b0;

    always @(posedge CLK or negedge RESET) begin
        logic [15:0] p;
        if (!RESET) begin
            m_cnt = 0;
            par_q.delete();
            exp_valid = 1'b0;
            exp_sym = 4'd0;
            exp_sof = 1'b0;
            exp_eof = 1'b0;
            m_inj = 1'b0;
        end else if (par_q.size() != 0) begin
            exp_sym = par_q.pop_front() ^ inj_err;
            if (inj_err != 4'd0) m_inj = 1'b1;
            exp_valid = 1'b1;
            exp_sof = 1'b0;
            exp_eof = (par_q.size() == 0);
        end else if (in_valid) begin
            if (m_cnt == 0) m_inj = 1'b0;
            if (inj_err != 4'd0) m_inj = 1'b1;
            m_msg[43-4*m_cnt -: 4] = in_symbol;
            exp_sym = in_symbol ^ inj_err;
            exp_valid = 1'b1;
            exp_sof = (m_cnt == 0);
            exp_eof = 1'b0;
            m_cnt++;
            if (m_cnt == 11) begin
                p = calc_parity(m_msg);
                par_q.push_back(p[15:12]);
                par_q.push_back(p[11:8]);
                par_q.push_back(p[7:4]);
                par_q.push_back(p[3:0]);
                clean_cw = {m_msg, p};
                m_cnt = 0;
            end
        end else begin
            exp_valid = 1'b0;
            exp_sof = 1'b0;
            exp_eof = 1'b0;
        end
        exp_ready = (par_q.size() == 0);
    end

    // ---------------- compare process ----------------
    logic [59:0] cw_acc = '0;
    logic [59:0] last_cw = '0;
    int cw_n = 0;
    int cw_done = 0;
    int ready_low = 0;

    always @(negedge CLK) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("out_sof", 64'(out_sof), 64'(exp_sof));
            chk("out_eof", 64'(out_eof), 64'(exp_eof));
            if (exp_valid || !RESET) chk("out_symbol", 64'(out_symbol), 64'(exp_sym));
            if (!RESET) begin
                cw_n = 0;
            end else begin
                if (!in_ready) ready_low++;
                if (out_valid) begin
                    if (out_sof) cw_n = 0;
                    if (cw_n < 15) cw_acc[59-4*cw_n -: 4] = out_symbol;
                    cw_n++;
                    if (out_eof && cw_n == 15) begin
                        last_cw = cw_acc;
                        cw_done++;
                        if (!m_inj)
                            for (int j = 0; j < 4; j++) chk("syndrome", 64'(syndrome(last_cw, j)), 64'd0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge CLK);
        #2;
    endtask

    task automatic send(input logic [3:0] sym, input int bubbles, input logic [3:0] inj);
        bit acc;
        int guard;
        for (int b = 0; b < bubbles; b++) begin
            in_valid = 1'b0;
            in_symbol = 4'($urandom_range(0, 15));
            cycle();
        end
        in_valid = 1'b1;
        in_symbol = sym;
        inj_err = inj;
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 50) begin
            acc = in_ready;
            cycle();
            guard++;
        end
        inj_err = 4'd0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept t=%0t", $time);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int d0;
        int guard;
        logic [3:0] ms [0:10];
        logic [43:0] msg;

        gexp[0] = 1;
        for (int i = 1; i < 15; i++) begin
            gexp[i] = gexp[i-1] << 1;
            if (gexp[i] & 16) gexp[i] = (gexp[i] ^ 16) ^ 3;
        end
        glog[0] = 0;
        for (int i = 0; i < 15; i++) glog[gexp[i]] = i;

        // Model pinned by hand-computed values.
        chk("model_par_g", 64'(calc_parity(44'h1)), 64'hF31C);
        chk("model_par_zero", 64'(calc_parity(44'h0)), 64'h0);
        chk("model_par_lead1", 64'(calc_parity(44'h1_0000_0000_0)), 64'(calc_parity(44'h1_0000_0000_0)) ^ 64'(syndrome(60'h00000000001F31C, 1)));
        chk("model_syn_g3", 64'(syndrome(60'h00000000001F31C, 3)), 64'h0);

        // Reset held with toggling stimulus.
        #1 RESET = 1'b0;
        started = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_symbol = 4'($urandom_range(0, 15));
            cycle();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        RESET = 1'b1;
        cycle();

        // All-zero message with in_valid held high through parity.
        ready_low = 0;
        d0 = cw_done;
        for (int i = 0; i < 11; i++) send(4'd0, 0, 4'd0);
        guard = 0;
        while (!in_ready && guard < 10) begin
            cycle();
            guard++;
        end
        idle(3);
        chk("zero_cw_count", 64'(cw_done), 64'(d0 + 1));
        chk("zero_cw", 64'(last_cw), 64'd0);
        chk("zero_ready_low", 64'(ready_low), 64'd4);

        // Message 0..0,1 gives g(x).
        d0 = cw_done;
        for (int i = 0; i < 10; i++) send(4'd0, 0, 4'd0);
        send(4'd1, 0, 4'd0);
        idle(6);
        chk("g_cw_count", 64'(cw_done), 64'(d0 + 1));
        chk("g_cw", 64'(last_cw), 64'h00000000001F31C);

        // Random messages with random bubbles.
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 11; i++)
                send(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 4'd0);
        end
        idle(6);

        // Reset after 6 accepted symbols.
        for (int i = 0; i < 6; i++) send(4'($urandom_range(0, 15)), 0, 4'd0);
        in_valid = 1'b0;
        RESET = 1'b0;
        cycle();
        cycle();
        RESET = 1'b1;
        cycle();
        d0 = cw_done;
        for (int i = 0; i < 11; i++) begin
            ms[i] = 4'($urandom_range(0, 15));
            msg[43-4*i -: 4] = ms[i];
            send(ms[i], 0, 4'd0);
        end
        idle(6);
        chk("midrst_cw_count", 64'(cw_done), 64'(d0 + 1));
        chk("midrst_cw", 64'(last_cw), 64'({msg, calc_parity(msg)}));

`ifdef RS_ENC_ERR_INJECT_EN
        // Error injection on codeword position 3 only.
        d0 = cw_done;
        for (int i = 0; i < 11; i++) begin
            ms[i] = 4'($urandom_range(0, 15));
            msg[43-4*i -: 4] = ms[i];
            send(ms[i], 0, (i == 3) ? 4'h5 : 4'h0);
        end
        idle(6);
        chk("inj_cw_count", 64'(cw_done), 64'(d0 + 1));
        chk("inj_cw", 64'(last_cw), 64'({msg, calc_parity(msg)} ^ (60'h5 << (4 * 11))));
        chk("inj_parity", 64'(last_cw[15:0]), 64'(calc_parity(msg)));
`endif

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
